// File: rtl/matrix_scan_rx.sv
// 8x8 switch matrix scanner: drives rows active-low, samples columns
// through a 2-flop synchronizer and debounces whole frames.
module matrix_scan_rx #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [7:0]  rows,
  input  logic [7:0]  columns,
  output logic [63:0] o_Data,
  output logic        o_Data_DV,
  output logic        o_Frame
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 2);
  localparam logic [7:0]  DEB_MAX     = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [2:0]       row;
  logic [2:0]       row_d;
  logic [15:0]      cnt;
  logic [15:0]      cnt_d;
  logic [7:0]       rows_d;
  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [6:0][7:0]  raw;
  logic [63:0]      cand;
  logic [7:0]       stable;
  logic             sample_go;
  logic             frame_end;

  logic [63:0]      frame_full;
  logic             same;
  logic [7:0]       stable_inc;
  logic [7:0]       stable_new;
  logic [63:0]      cand_new;
  logic             publish;

  always_comb begin
    state_d   = state;
    row_d     = row;
    cnt_d     = cnt;
    sample_go = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_d = DRIVE;
          row_d   = 3'd0;
          cnt_d   = 16'd0;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
          if (cnt == SETTLE_LAST) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        sample_go = 1'b1;
        if (!enable) begin
          state_d = IDLE;
        end else begin
          state_d   = DRIVE;
          cnt_d     = 16'd0;
          row_d     = row + 3'd1;
          frame_end = (row == 3'd7);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rows_d = 8'hFF;
    if (state_d != IDLE) begin
      rows_d = ~(8'h01 << row_d);
    end
  end

  // Row 7 is folded in straight from the synchronizer so the
  // frame can be judged on the same edge that samples it.
  always_comb begin
    frame_full = {~sync2, raw};
    same       = (frame_full == cand);
    stable_inc = (stable >= DEB_MAX) ? DEB_MAX : stable + 8'd1;
    stable_new = same ? stable_inc : 8'd1;
    cand_new   = same ? cand : frame_full;
    publish    = (stable_new == DEB_MAX) && (cand_new != o_Data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
    end else begin
      sync1 <= columns;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= 3'd0;
      cnt   <= 16'd0;
      rows  <= 8'hFF;
    end else begin
      state <= state_d;
      row   <= row_d;
      cnt   <= cnt_d;
      rows  <= rows_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw <= '0;
    end else if (sample_go && (row != 3'd7)) begin
      raw[row] <= ~sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= 64'd0;
      stable    <= 8'd0;
      o_Data    <= 64'd0;
      o_Data_DV <= 1'b0;
      o_Frame   <= 1'b0;
    end else begin
      o_Frame   <= frame_end;
      o_Data_DV <= frame_end && publish;
      if (frame_end) begin
        cand   <= cand_new;
        stable <= stable_new;
        if (publish) begin
          o_Data <= cand_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_rx.sv
// Randomized bench for matrix_scan_rx against a frame-level
// reference model of scan timing and debounce.
module tb_matrix_scan_rx;

  localparam int S = 4;
  localparam int D = 3;
  localparam int FL = 8 * S;
  localparam logic [63:0] B21 = 64'h0000_0000_0020_0000;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  rows;
  logic [7:0]  columns;
  logic [63:0] o_Data;
  logic        o_Data_DV;
  logic        o_Frame;

  logic [63:0] keys;

  int n_checks;
  int n_errors;

  matrix_scan_rx #(
    .SETTLE_CYCLES (S),
    .DEBOUNCE_SCANS(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .rows     (rows),
    .columns  (columns),
    .o_Data   (o_Data),
    .o_Data_DV(o_Data_DV),
    .o_Frame  (o_Frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    columns = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if (rows == ~(8'h01 << r)) columns = ~keys[r*8 +: 8];
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: t is the cycle index inside the current scan.
  int          t;
  logic [63:0] raw_m;
  logic [63:0] hist[$];
  logic [63:0] exp_data;
  logic        exp_dv;
  logic        exp_frame;

  function automatic logic [7:0] exp_rows();
    if (t < 0) return 8'hFF;
    return ~(8'h01 << (t / S));
  endfunction

  task automatic eval_frame();
    bit all_same;
    hist.push_back(raw_m);
    if (hist.size() > D) hist.delete(0);
    all_same = (hist.size() == D);
    foreach (hist[i]) if (hist[i] != hist[0]) all_same = 0;
    if (all_same && hist[0] != exp_data) begin
      exp_data = hist[0];
      exp_dv   = 1'b1;
    end
  endtask

  initial begin
    t = -1; raw_m = '0; exp_data = '0; exp_dv = 0; exp_frame = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      exp_frame = 1'b0;
      exp_dv    = 1'b0;
      if (!rst_n) begin
        t = -1; raw_m = '0; exp_data = '0; hist.delete();
      end else if (t < 0) begin
        if (enable) t = 0;
      end else if (!enable) begin
        t = -1;
      end else begin
        if (t % S == S - 1) raw_m[(t/S)*8 +: 8] = keys[(t/S)*8 +: 8];
        if (t == FL - 1) begin
          eval_frame();
          exp_frame = 1'b1;
          t = 0;
        end else begin
          t++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("rows", {56'd0, rows}, {56'd0, exp_rows()});
      check("frame", {63'd0, o_Frame}, {63'd0, exp_frame});
      check("dv", {63'd0, o_Data_DV}, {63'd0, exp_dv});
      check("data", o_Data, exp_data);
    end
  end

  task automatic wait_frame();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_frame) return;
    end
    check("frame_timeout", 64'd0, 64'd1);
  endtask

  task automatic play(input logic [63:0] k);
    keys = k;
    wait_frame();
  endtask

  task automatic wait_t(input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (t == target) return;
    end
    check("t_timeout", 64'd0, 64'd1);
  endtask

  logic [63:0] pool[4];
  logic [63:0] held;

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; enable = 1'b0; keys = '0;
    repeat (3) @(negedge clk);
    check("rst_rows", {56'd0, rows}, 64'hFF);
    check("rst_data", o_Data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("first_row", {56'd0, rows}, 64'hFE);

    repeat (4) play(64'd0);
    check("idle_data", o_Data, 64'd0);

    play(B21); play(B21);
    check("deb_hold", o_Data, 64'd0);
    play(B21);
    check("deb_dv", {63'd0, o_Data_DV}, 64'd1);
    check("deb_data", o_Data, B21);

    play(64'd0); play(64'd0);
    check("rel_hold", o_Data, B21);
    play(64'd0);
    check("rel_dv", {63'd0, o_Data_DV}, 64'd1);
    check("rel_data", o_Data, 64'd0);

    play(B21); play(B21); play(64'd0);
    play(B21); play(B21);
    check("bounce_hold", o_Data, 64'd0);
    play(B21);
    check("bounce_data", o_Data, B21);

    wait_t(3 * S);
    held = o_Data;
    enable = 1'b0;
    @(negedge clk);
    check("dis_rows", {56'd0, rows}, 64'hFF);
    repeat (FL + 4) @(negedge clk);
    check("dis_data", o_Data, held);
    enable = 1'b1;
    @(negedge clk);
    check("reen_row", {56'd0, rows}, 64'hFE);

    wait_t(FL - 1);
    enable = 1'b0;
    @(negedge clk);
    check("r7_noframe", {63'd0, o_Frame}, 64'd0);
    repeat (3) @(negedge clk);
    enable = 1'b1;

    pool[0] = 64'd0;
    pool[1] = B21;
    pool[2] = {$urandom, $urandom};
    pool[3] = {$urandom, $urandom};
    for (int it = 0; it < 25; it++) begin
      logic [63:0] k;
      k = pool[$urandom_range(0, 3)];
      repeat ($urandom_range(1, 4)) play(k);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, FL - 2)) @(negedge clk);
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        enable = 1'b1;
      end
    end

    pool[2] = pool[2] | 64'd1;
    repeat (D) play(pool[2]);
    check("pre_rst_data", o_Data, pool[2]);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", o_Data, 64'd0);
    check("arst_rows", {56'd0, rows}, 64'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_row", {56'd0, rows}, 64'hFE);
    play(pool[2]); play(pool[2]);
    check("post_rst_hold", o_Data, 64'd0);
    play(pool[2]);
    check("post_rst_data", o_Data, pool[2]);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
